// File: rtl/radix8_mag_multiplier_if.sv
// Operand/result handshake bundle for the radix-8 magnitude multiplier.
// The slave side is the multiplier; the master side feeds operands and
// consumes the sign flags and the unsigned magnitude product.
interface radix8_mag_multiplier_if;
  logic        iValid;
  logic        oReady;
  logic [7:0]  iDatA;
  logic [7:0]  iDatB;
  logic        oValid;
  logic        iReady;
  logic        oNegativeA;
  logic        oNegativeB;
  logic [13:0] oMagProduct;
  logic        oClamp;

  modport slave (
    input  iValid, iDatA, iDatB, iReady,
    output oReady, oValid, oNegativeA, oNegativeB, oMagProduct, oClamp
  );

  modport master (
    output iValid, iDatA, iDatB, iReady,
    input  oReady, oValid, oNegativeA, oNegativeB, oMagProduct, oClamp
  );
endinterface

// File: rtl/radix8_mag_multiplier.sv
// Sequential radix-8 Booth magnitude multiplier.
// Operands are reduced to 7-bit magnitudes (-128 clamps to 127). A PRE cycle
// builds the hard multiple 3*|A|, then three ITER cycles add one Booth digit
// each into a 17-bit signed accumulator. The sign is left to the next stage.

// Partial product for one radix-8 Booth group {b2,b1,b0,b-1}.
module radix8_booth_pp (
  input  logic [6:0]  mag_a,
  input  logic [8:0]  mul3_a,
  input  logic [3:0]  grp,
  output logic [16:0] pp
);
  logic [8:0] mult;
  logic       neg;

  // Decode digit in {-4..+4} to a selected multiple plus a negate flag.
  always_comb begin
    mult = '0;
    neg  = 1'b0;
    case (grp)
      4'b0001, 4'b0010: mult = {2'b00, mag_a};
      4'b0011, 4'b0100: mult = {1'b0, mag_a, 1'b0};
      4'b0101, 4'b0110: mult = mul3_a;
      4'b0111:          mult = {mag_a, 2'b00};
      4'b1000:          begin mult = {mag_a, 2'b00};       neg = 1'b1; end
      4'b1001, 4'b1010: begin mult = mul3_a;               neg = 1'b1; end
      4'b1011, 4'b1100: begin mult = {1'b0, mag_a, 1'b0};  neg = 1'b1; end
      4'b1101, 4'b1110: begin mult = {2'b00, mag_a};       neg = 1'b1; end
      default:          mult = '0;
    endcase
    pp = neg ? (17'd0 - {8'd0, mult}) : {8'd0, mult};
  end
endmodule

module radix8_mag_multiplier (
  input logic                   iClk,
  input logic                   iRst_n,
  radix8_mag_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [16:0] acc_q, acc_d;
  logic [6:0]  mag_a_q, mag_a_d;
  logic [6:0]  mag_b_q, mag_b_d;
  logic [8:0]  mul3_q, mul3_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        clamp_q, clamp_d;
  logic [13:0] prod_q, prod_d;
  logic        rdy_q, rdy_d;
  logic        vld_q, vld_d;

  logic [9:0]  ext_b;
  logic [3:0]  grp;
  logic [16:0] pp;
  logic [16:0] pp_sh;
  logic [16:0] acc_sum;

  // |x| in 7 bits; -128 has no 7-bit magnitude and saturates to 127.
  function automatic logic [6:0] mag7(input logic [7:0] x);
    logic [7:0] n;
    n = 8'd0 - x;
    if (x == 8'h80)  return 7'h7F;
    else if (x[7])   return n[6:0];
    else             return x[6:0];
  endfunction

  // |B| zero-extended to 9 bits with the implicit 0 below bit 0.
  assign ext_b = {2'b00, mag_b_q, 1'b0};

  // Pick the overlapping 4-bit group for the current digit, LSB group first.
  always_comb begin
    case (cnt_q)
      2'd0:    grp = ext_b[3:0];
      2'd1:    grp = ext_b[6:3];
      default: grp = ext_b[9:6];
    endcase
  end

  radix8_booth_pp u_pp (
    .mag_a  (mag_a_q),
    .mul3_a (mul3_q),
    .grp    (grp),
    .pp     (pp)
  );

  // Weight the partial product by 8^counter; wrap in 17 bits is harmless.
  always_comb begin
    case (cnt_q)
      2'd0:    pp_sh = pp;
      2'd1:    pp_sh = pp << 3;
      default: pp_sh = pp << 6;
    endcase
  end

  assign acc_sum = acc_q + pp_sh;

  // Next-state and datapath updates for the IDLE/PRE/ITER/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    mul3_d  = mul3_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    clamp_d = clamp_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          neg_a_d = bus.iDatA[7];
          neg_b_d = bus.iDatB[7];
          mag_a_d = mag7(bus.iDatA);
          mag_b_d = mag7(bus.iDatB);
          clamp_d = (bus.iDatA == 8'h80) || (bus.iDatB == 8'h80);
          acc_d   = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        mul3_d  = {2'b00, mag_a_q} + {1'b0, mag_a_q, 1'b0};
        cnt_d   = 2'd0;
        state_d = ITER;
      end
      ITER: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          prod_d  = acc_sum[13:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
    vld_d = (state_d == DONE);
  end

  // State and registered handshake/result outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      mul3_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      clamp_q <= 1'b0;
      prod_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      mul3_q  <= mul3_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      clamp_q <= clamp_d;
      prod_q  <= prod_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.oReady      = rdy_q;
  assign bus.oValid      = vld_q;
  assign bus.oNegativeA  = neg_a_q;
  assign bus.oNegativeB  = neg_b_q;
  assign bus.oMagProduct = prod_q;
  assign bus.oClamp      = clamp_q;
endmodule

// File: tb/tb_radix8_mag_multiplier.sv
// Directed and swept checks of the radix-8 magnitude multiplier with a
// queue-based scoreboard of expected results.
module tb_radix8_mag_multiplier;
  logic iClk;
  logic iRst_n;

  radix8_mag_multiplier_if bus ();

  radix8_mag_multiplier dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic        na;
    logic        nb;
    logic [13:0] prod;
    logic        clamp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, ma, mb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (ma > 127) ma = 127;
    if (mb > 127) mb = 127;
    e.na    = a[7];
    e.nb    = b[7];
    e.prod  = 14'(ma * mb);
    e.clamp = (a == 8'h80) || (b == 8'h80);
    return e;
  endfunction

  // One operation: drive, check fixed latency, pop scoreboard, optionally
  // stall the output for 'hold' cycles, then check the return to IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    @(negedge iClk);
    bus.iValid = 1'b1;
    bus.iDatA  = a;
    bus.iDatB  = b;
    bus.iReady = (hold == 0);
    chk("in_ready", 32'(bus.oReady), 32'd1);
    sbq.push_back(model(a, b));
    for (int k = 1; k <= 4; k++) begin
      @(negedge iClk);
      if (k == 1) begin
        // Junk while busy must be ignored.
        bus.iDatA = ~a;
        bus.iDatB = ~b + 8'd1;
      end
      if (k == 4) bus.iValid = 1'b0;
      chk("lat_lo", 32'(bus.oValid), 32'd0);
      chk("busy_rdy", 32'(bus.oReady), 32'd0);
    end
    @(negedge iClk);
    chk("lat_hi", 32'(bus.oValid), 32'd1);
    chk("sb_depth", 32'(sbq.size()), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("neg_a", 32'(bus.oNegativeA), 32'(e.na));
      chk("neg_b", 32'(bus.oNegativeB), 32'(e.nb));
      chk("prod", 32'(bus.oMagProduct), 32'(e.prod));
      chk("clamp", 32'(bus.oClamp), 32'(e.clamp));
      chk("done_rdy", 32'(bus.oReady), 32'd0);
      for (int h = 1; h < hold; h++) begin
        @(negedge iClk);
        chk("hold_vld", 32'(bus.oValid), 32'd1);
        chk("hold_prod", 32'(bus.oMagProduct), 32'(e.prod));
        chk("hold_rdy", 32'(bus.oReady), 32'd0);
      end
    end
    bus.iReady = 1'b1;
    @(negedge iClk);
    chk("post_vld", 32'(bus.oValid), 32'd0);
    chk("post_rdy", 32'(bus.oReady), 32'd1);
  endtask

  logic [7:0] bset [32];

  initial begin
    iRst_n     = 1'b1;
    bus.iValid = 1'b0;
    bus.iDatA  = '0;
    bus.iDatB  = '0;
    bus.iReady = 1'b1;
    #1 iRst_n = 1'b0;
    #10;
    chk("rst_rdy", 32'(bus.oReady), 32'd1);
    chk("rst_vld", 32'(bus.oValid), 32'd0);
    chk("rst_na", 32'(bus.oNegativeA), 32'd0);
    chk("rst_nb", 32'(bus.oNegativeB), 32'd0);
    chk("rst_prod", 32'(bus.oMagProduct), 32'd0);
    chk("rst_clamp", 32'(bus.oClamp), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;

    // Directed vectors.
    run_op(8'h05, 8'hFD, 0);
    run_op(8'h7F, 8'h7F, 0);
    run_op(8'h80, 8'h02, 0);

    // Reset during ITER discards the operation.
    @(negedge iClk);
    bus.iValid = 1'b1;
    bus.iDatA  = 8'h80;
    bus.iDatB  = 8'hB3;
    sbq.push_back(model(8'h80, 8'hB3));
    @(negedge iClk);
    bus.iValid = 1'b0;
    @(negedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(bus.oReady), 32'd1);
    chk("mid_rst_vld", 32'(bus.oValid), 32'd0);
    chk("mid_rst_na", 32'(bus.oNegativeA), 32'd0);
    chk("mid_rst_prod", 32'(bus.oMagProduct), 32'd0);
    chk("mid_rst_clamp", 32'(bus.oClamp), 32'd0);
    sbq.delete();
    @(negedge iClk);
    iRst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk);
      chk("no_ghost_vld", 32'(bus.oValid), 32'd0);
    end
    run_op(8'hF9, 8'hF9, 0);

    // Output stall with a zero operand.
    run_op(8'h13, 8'h00, 6);
    run_op(8'h80, 8'h80, 0);
    run_op(8'h00, 8'h80, 2);
    run_op(8'h81, 8'h7F, 0);

    // Sweep every A against boundary and random B values.
    bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h02; bset[3] = 8'h03;
    bset[4] = 8'h04; bset[5] = 8'h07; bset[6] = 8'h7F; bset[7] = 8'h80;
    bset[8] = 8'h81; bset[9] = 8'hFE; bset[10] = 8'hFF; bset[11] = 8'h40;
    bset[12] = 8'h3F; bset[13] = 8'hC0; bset[14] = 8'h24; bset[15] = 8'hDB;
    for (int i = 16; i < 32; i++) bset[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 32; j++)
        run_op(8'(a), bset[j], 0);

    chk("sb_final", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
